// File: rtl/sudoku_board_loader.sv
// Streams CELLS digits row-major into a shadow board, commits the shadow to
// init_board in one cycle, then pulses start to the game controller.
module sudoku_board_loader #(
  parameter int CELLS   = 81,
  parameter int DIGIT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_req,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic [DIGIT_W-1:0]       in_digit,
  output logic                     in_ready,
  output logic [CELLS*DIGIT_W-1:0] init_board,
  output logic [CELLS-1:0]         init_board_blank,
  output logic                     start,
  output logic                     busy,
  output logic                     error,
  output logic [6:0]               cell_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, START, ERR} state_t;

  localparam logic [6:0]         LAST_IDX  = 7'(CELLS - 1);
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(9);

  state_t                   state;
  logic [CELLS*DIGIT_W-1:0] shadow;
  logic [CELLS-1:0]         shadow_blank;

  assign in_ready = (state == LOAD) && !abort;
  assign start    = (state == START);
  assign busy     = (state == LOAD) || (state == COMMIT) || (state == START);
  assign error    = (state == ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cell_cnt         <= '0;
      shadow           <= '0;
      shadow_blank     <= '0;
      init_board       <= '0;
      init_board_blank <= '0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (load_req) begin
            state        <= LOAD;
            cell_cnt     <= '0;
            shadow       <= '0;
            shadow_blank <= '0;
          end
        end
        LOAD: begin
          // abort outranks in_valid: nothing is taken on the abort cycle
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            if (in_digit > MAX_DIGIT) begin
              state <= ERR;
            end else begin
              shadow[int'(cell_cnt)*DIGIT_W +: DIGIT_W] <= in_digit;
              shadow_blank[cell_cnt]                    <= (in_digit == '0);
              cell_cnt                                  <= cell_cnt + 7'd1;
              if (cell_cnt == LAST_IDX) state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          init_board       <= shadow;
          init_board_blank <= shadow_blank;
          state            <= START;
        end
        START:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_board_loader.sv
// Directed bench for sudoku_board_loader: a cell-array model is checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_sudoku_board_loader;

  logic         clk = 1'b0;
  logic         reset, load_req, abort, in_valid;
  logic [3:0]   in_digit;
  logic         in_ready, start, busy, error;
  logic [323:0] init_board;
  logic [80:0]  init_board_blank;
  logic [6:0]   cell_cnt;

  sudoku_board_loader #(.CELLS(81), .DIGIT_W(4)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .abort(abort),
    .in_valid(in_valid), .in_digit(in_digit), .in_ready(in_ready),
    .init_board(init_board), .init_board_blank(init_board_blank),
    .start(start), .busy(busy), .error(error), .cell_cnt(cell_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [323:0] act, input logic [323:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] dig(input int i);
    if (i == 0 || i == 80) return 4'd0;
    return 4'((i % 9) + 1);
  endfunction

  // Model: loading flag, error flag, and a countdown of the cycles left after
  // the last cell (2 = commit pending, 1 = start visible).
  bit         m_load, m_err;
  int         m_tail, m_cnt;
  logic [3:0] m_sh [81];
  logic [3:0] m_brd[81];
  logic [80:0] m_sb, m_bb;
  int         edge_no = 0;
  int         acc_edge = -100;

  initial begin
    forever begin
      @(posedge clk);
      edge_no++;
      if (reset) begin
        m_load = 0; m_err = 0; m_tail = 0; m_cnt = 0; m_sb = '0; m_bb = '0;
        for (int i = 0; i < 81; i++) begin m_sh[i] = 0; m_brd[i] = 0; end
      end else if (m_tail > 0) begin
        if (m_tail == 2) begin
          for (int i = 0; i < 81; i++) m_brd[i] = m_sh[i];
          m_bb = m_sb;
        end
        m_tail--;
      end else if (m_load) begin
        if (abort) m_load = 0;
        else if (in_valid) begin
          if (in_digit > 9) begin
            m_load = 0; m_err = 1;
          end else begin
            m_sh[m_cnt] = in_digit;
            m_sb[m_cnt] = (in_digit == 0);
            m_cnt++;
            if (m_cnt == 81) begin m_load = 0; m_tail = 2; acc_edge = edge_no; end
          end
        end
      end else if (load_req) begin
        m_load = 1; m_err = 0; m_cnt = 0; m_sb = '0;
        for (int i = 0; i < 81; i++) m_sh[i] = 0;
      end
    end
  end

  int ir_cnt = 0;
  int st_cnt = 0;

  initial begin
    logic [323:0] eb;
    forever begin
      @(posedge clk);
      #1;
      eb = '0;
      for (int i = 0; i < 81; i++) eb[i*4 +: 4] = m_brd[i];
      chk("in_ready", in_ready, m_load && !abort);
      chk("busy", busy, m_load || m_tail > 0);
      chk("start", start, m_tail == 1);
      chk("error", error, m_err);
      chk("cell_cnt", cell_cnt, m_cnt);
      chk("init_board", init_board, eb);
      chk("init_board_blank", init_board_blank, m_bb);
      if (in_ready) ir_cnt++;
      if (start) begin
        st_cnt++;
        chk("start_latency", edge_no, acc_edge + 1);
      end
    end
  end

  task automatic feed(input int from, input int to, input bit toggle);
    for (int i = from; i < to; i++) begin
      in_valid = 1; in_digit = dig(i); @(negedge clk);
      if (toggle) begin in_valid = 0; in_digit = 4'hF; @(negedge clk); end
    end
    in_valid = 0;
  endtask

  task automatic req();
    load_req = 1; @(negedge clk); load_req = 0;
  endtask

  initial begin
    int sb, ib;
    reset = 1; load_req = 0; abort = 0; in_valid = 0; in_digit = 0;
    repeat (3) @(negedge clk);
    chk("rst_board", init_board, '0);
    chk("rst_flags", {in_ready, start, busy, error}, 4'b0000);
    chk("rst_cnt", cell_cnt, 7'd0);
    reset = 0;
    @(negedge clk);

    // Full load with in_valid held high
    sb = st_cnt; ib = ir_cnt;
    req();
    feed(0, 81, 0);
    repeat (3) @(negedge clk);
    chk("full_ready_cycles", ir_cnt - ib, 81);
    chk("full_starts", st_cnt - sb, 1);
    chk("full_cell0", init_board[3:0], 4'd0);
    chk("full_cell1", init_board[7:4], 4'd2);
    chk("full_cell80", init_board[323:320], 4'd0);
    chk("full_cell9", init_board[39:36], 4'd1);
    chk("full_blank", init_board_blank, 81'h1 | (81'h1 << 80));

    // Alternating valid/stall cycles
    sb = st_cnt;
    req();
    feed(0, 81, 1);
    repeat (3) @(negedge clk);
    chk("toggle_cnt", cell_cnt, 7'd81);
    chk("toggle_starts", st_cnt - sb, 1);

    // Illegal digit at cell 5
    req();
    feed(0, 5, 0);
    in_valid = 1; in_digit = 4'hC; @(negedge clk); in_valid = 0;
    chk("bad_error", error, 1'b1);
    chk("bad_cnt", cell_cnt, 7'd5);
    chk("bad_ready", in_ready, 1'b0);
    chk("bad_board_kept", init_board[7:4], 4'd2);
    req();
    chk("bad_recover_error", error, 1'b0);
    chk("bad_recover_cnt", cell_cnt, 7'd0);

    // Abort at cell 40 with a digit offered
    sb = st_cnt;
    feed(0, 40, 0);
    abort = 1; in_valid = 1; in_digit = 4'd7; @(negedge clk);
    abort = 0; in_valid = 0;
    chk("abort_cnt", cell_cnt, 7'd40);
    chk("abort_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    chk("abort_starts", st_cnt - sb, 0);
    chk("abort_board_kept", init_board[7:4], 4'd2);

    // Reset in the middle of a load, then a clean load
    req();
    feed(0, 60, 0);
    chk("mid_cnt", cell_cnt, 7'd60);
    reset = 1; @(negedge clk); reset = 0;
    chk("mid_rst_board", init_board, '0);
    chk("mid_rst_blank", init_board_blank, '0);
    chk("mid_rst_flags", {in_ready, start, busy, error, cell_cnt}, 11'd0);
    sb = st_cnt;
    req();
    feed(0, 81, 0);
    repeat (3) @(negedge clk);
    chk("post_rst_starts", st_cnt - sb, 1);
    chk("post_rst_cell1", init_board[7:4], 4'd2);

    // load_req during LOAD and during START is ignored
    sb = st_cnt;
    req();
    feed(0, 10, 0);
    load_req = 1; feed(10, 11, 0); load_req = 0;
    chk("ign_cnt", cell_cnt, 7'd11);
    feed(11, 81, 0);
    @(negedge clk);
    chk("ign_start_now", start, 1'b1);
    load_req = 1; @(negedge clk); load_req = 0;
    repeat (3) @(negedge clk);
    chk("ign_starts", st_cnt - sb, 1);
    chk("ign_idle", {busy, cell_cnt}, {1'b0, 7'd81});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
